// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Optional feature macro: MEM_ARB_STARVE_GUARD_EN (see mem_port_arbiter).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CPU        = 2'd1,
    LDR        = 2'd2,
    LDR_LOCKED = 2'd3
  } arbState_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  localparam int HOLD_MAX_DEF = 4;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Counts CPU grants made while the loader waits and forces
// a loader turn once HOLD_MAX of them have gone by.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic Clk,
  input  logic Reset,
  input  logic CpuGnt,
  input  logic LdrGnt,
  input  logic LdrReq,
  output logic ForceLdr
);

  logic [2:0] holdCnt;

  // Hold counter: cleared when the loader gets in or stops asking
  always_ff @(posedge Clk) begin
    if (Reset || LdrGnt || !LdrReq) begin
      holdCnt <= 3'd0;
    end else if (CpuGnt) begin
      holdCnt <= holdCnt + 3'd1;
    end
  end

  assign ForceLdr = LdrReq && (holdCnt == 3'(HOLD_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// CPU / loader arbiter in front of the single-ported data memory.
// Macro MEM_ARB_STARVE_GUARD_EN adds the loader starvation guard.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              CpuReq,
  input  logic              CpuWe,
  input  logic [ADDR_W-1:0] CpuAddr,
  input  logic [DATA_W-1:0] CpuWData,
  input  logic              LdrReq,
  input  logic              LdrWe,
  input  logic [ADDR_W-1:0] LdrAddr,
  input  logic [DATA_W-1:0] LdrWData,
  input  logic              LdrLock,
  output logic              CpuGnt,
  output logic              LdrGnt,
  output logic              CpuRValid,
  output logic              LdrRValid,
  output logic [DATA_W-1:0] CpuRData,
  output logic [DATA_W-1:0] LdrRData,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemWriteData,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] MemReadData
);

  arbState_t state;
  arbState_t stateNxt;
  logic      pickCpu;
  logic      pickLdr;
  logic      grantCpu;
  logic      grantLdr;
  logic      forceLdr;
  logic      rdPend;
  logic      rdOwner;

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve_ctr #(
    .HOLD_MAX(HOLD_MAX)
  ) uStarve (
    .Clk     (Clk),
    .Reset   (Reset),
    .CpuGnt  (grantCpu),
    .LdrGnt  (grantLdr),
    .LdrReq  (LdrReq),
    .ForceLdr(forceLdr)
  );
`else
  // No guard: the loader is never forced in (always 0 for legal HOLD_MAX)
  assign forceLdr = (HOLD_MAX < 0);
`endif

  // Owner register and read-return tracking
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      rdPend  <= 1'b0;
      rdOwner <= REQ_CPU;
    end else begin
      state   <= stateNxt;
      rdPend  <= MemRead;
      rdOwner <= grantLdr ? REQ_LDR : REQ_CPU;
    end
  end

  // Grant decision and next owner
  always_comb begin
    pickCpu  = 1'b0;
    pickLdr  = 1'b0;
    stateNxt = IDLE;
    if (state == LDR_LOCKED) begin
      pickLdr  = LdrReq;
      stateNxt = LdrLock ? LDR_LOCKED : IDLE;
    end else begin
      pickCpu = CpuReq && !forceLdr;
      pickLdr = LdrReq && !pickCpu;
      unique case (1'b1)
        pickCpu: stateNxt = CPU;
        pickLdr: stateNxt = LdrLock ? LDR_LOCKED : LDR;
        default: stateNxt = IDLE;
      endcase
    end
  end

  // Nothing is granted while reset is held
  assign grantCpu = pickCpu && !Reset;
  assign grantLdr = pickLdr && !Reset;
  assign CpuGnt   = grantCpu;
  assign LdrGnt   = grantLdr;

  // Route the granted requester onto the memory port
  always_comb begin
    MemAddress   = '0;
    MemWriteData = '0;
    MemWrite     = 1'b0;
    MemRead      = 1'b0;
    unique case (1'b1)
      grantCpu: begin
        MemAddress   = CpuAddr;
        MemWriteData = CpuWData;
        MemWrite     = CpuWe;
        MemRead      = !CpuWe;
      end
      grantLdr: begin
        MemAddress   = LdrAddr;
        MemWriteData = LdrWData;
        MemWrite     = LdrWe;
        MemRead      = !LdrWe;
      end
      default: ;
    endcase
  end

  assign CpuRValid = rdPend && (rdOwner == REQ_CPU) && !Reset;
  assign LdrRValid = rdPend && (rdOwner == REQ_LDR) && !Reset;
  assign CpuRData  = CpuRValid ? MemReadData : '0;
  assign LdrRData  = LdrRValid ? MemReadData : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed checks of mem_port_arbiter against a
// behavioural model of the arbitration rules.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int HOLD = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        CpuReq, CpuWe, LdrReq, LdrWe, LdrLock;
  logic [31:0] CpuAddr, CpuWData, LdrAddr, LdrWData;
  logic        CpuGnt, LdrGnt, CpuRValid, LdrRValid;
  logic [31:0] CpuRData, LdrRData;
  logic [31:0] MemAddress, MemWriteData;
  logic        MemWrite, MemRead;
  logic [31:0] memRData;

  logic [31:0] mem [0:255];

  int nRun = 0;
  int nFail = 0;

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (MemWrite) mem[MemAddress[7:0]] <= MemWriteData;
    if (MemRead) memRData <= mem[MemAddress[7:0]];
  end

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .HOLD_MAX(HOLD)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .CpuReq(CpuReq), .CpuWe(CpuWe),
    .CpuAddr(CpuAddr), .CpuWData(CpuWData),
    .LdrReq(LdrReq), .LdrWe(LdrWe),
    .LdrAddr(LdrAddr), .LdrWData(LdrWData),
    .LdrLock(LdrLock),
    .CpuGnt(CpuGnt), .LdrGnt(LdrGnt),
    .CpuRValid(CpuRValid), .LdrRValid(LdrRValid),
    .CpuRData(CpuRData), .LdrRData(LdrRData),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemWrite(MemWrite), .MemRead(MemRead),
    .MemReadData(memRData)
  );

  task automatic nextCycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic idleInputs();
    CpuReq = 0; CpuWe = 0; CpuAddr = 0; CpuWData = 0;
    LdrReq = 0; LdrWe = 0; LdrAddr = 0; LdrWData = 0;
    LdrLock = 0;
  endtask

  task automatic ldrWrite(input logic [31:0] a, input logic [31:0] d);
    LdrReq = 1; LdrWe = 1; LdrAddr = a; LdrWData = d;
    @(negedge Clk);
    nextCycle();
    LdrReq = 0; LdrWe = 0;
  endtask

  task automatic test_reset();
    logic [165:0] allOut;
    Reset = 1;
    idleInputs();
    nextCycle();
    nextCycle();
    @(negedge Clk);
    allOut = {CpuGnt, LdrGnt, CpuRValid, LdrRValid, MemWrite, MemRead,
              MemAddress, MemWriteData, CpuRData, LdrRData};
    nRun++;
    if (allOut !== '0) begin
      nFail++;
      $display("FAIL reset_hold: got %h want 0", allOut);
    end
    nextCycle();
    Reset = 0;
    @(negedge Clk);
    allOut = {CpuGnt, LdrGnt, CpuRValid, LdrRValid, MemWrite, MemRead,
              MemAddress, MemWriteData, CpuRData, LdrRData};
    nRun++;
    if (allOut !== '0) begin
      nFail++;
      $display("FAIL reset_release: got %h want 0", allOut);
    end
    nextCycle();
  endtask

  task automatic test_cpu_read();
    ldrWrite(32'h10, 32'hDEADBEEF);
    CpuReq = 1; CpuWe = 0; CpuAddr = 32'h10;
    @(negedge Clk);
    nRun++;
    if ({CpuGnt, LdrGnt, MemRead, MemWrite, MemAddress}
        !== {4'b1010, 32'h10}) begin
      nFail++;
      $display("FAIL cpu_read_gnt: got %b %b %b %b %h want 1 0 1 0 10",
               CpuGnt, LdrGnt, MemRead, MemWrite, MemAddress);
    end
    nextCycle();
    CpuReq = 0;
    @(negedge Clk);
    nRun++;
    if ({CpuRValid, LdrRValid, CpuRData, LdrRData}
        !== {2'b10, 32'hDEADBEEF, 32'h0}) begin
      nFail++;
      $display("FAIL cpu_read_ret: got v=%b%b cd=%h ld=%h want 10 deadbeef 0",
               CpuRValid, LdrRValid, CpuRData, LdrRData);
    end
    nextCycle();
  endtask

  task automatic test_both_writes();
    CpuReq = 1; CpuWe = 1; CpuAddr = 32'h20; CpuWData = 32'h11111111;
    LdrReq = 1; LdrWe = 1; LdrAddr = 32'h21; LdrWData = 32'h22222222;
    @(negedge Clk);
    nRun++;
    if ({CpuGnt, LdrGnt, MemWrite, MemRead, MemWriteData}
        !== {4'b1010, 32'h11111111}) begin
      nFail++;
      $display("FAIL both_cpu_first: got %b%b%b%b %h want 1010 11111111",
               CpuGnt, LdrGnt, MemWrite, MemRead, MemWriteData);
    end
    nextCycle();
    CpuReq = 0;
    @(negedge Clk);
    nRun++;
    if ({CpuGnt, LdrGnt, MemWrite, MemRead, CpuRValid, LdrRValid,
         MemAddress, MemWriteData}
        !== {6'b011000, 32'h21, 32'h22222222}) begin
      nFail++;
      $display("FAIL both_ldr_next: got %b%b%b%b v=%b%b %h %h want 0110 00 21 22222222",
               CpuGnt, LdrGnt, MemWrite, MemRead, CpuRValid, LdrRValid,
               MemAddress, MemWriteData);
    end
    nextCycle();
    LdrReq = 0;
    CpuReq = 1; CpuWe = 0; CpuAddr = 32'h21;
    @(negedge Clk);
    nRun++;
    if ({CpuRValid, LdrRValid, CpuGnt} !== 3'b001) begin
      nFail++;
      $display("FAIL write_no_rvalid: got %b%b%b want 001",
               CpuRValid, LdrRValid, CpuGnt);
    end
    nextCycle();
    CpuReq = 0;
    @(negedge Clk);
    nRun++;
    if ({CpuRValid, CpuRData} !== {1'b1, 32'h22222222}) begin
      nFail++;
      $display("FAIL both_readback: got %b %h want 1 22222222",
               CpuRValid, CpuRData);
    end
    nextCycle();
  endtask

  task automatic test_lock();
    LdrLock = 1;
    @(negedge Clk);
    nextCycle();
    CpuReq = 1; CpuWe = 1; CpuAddr = 32'h30;
    @(negedge Clk);
    nRun++;
    if ({CpuGnt, LdrGnt} !== 2'b10) begin
      nFail++;
      $display("FAIL lock_no_req_ignored: got %b%b want 10", CpuGnt, LdrGnt);
    end
    nextCycle();
    CpuReq = 0;
    LdrReq = 1; LdrWe = 1; LdrAddr = 32'h0; LdrWData = 32'hA0;
    @(negedge Clk);
    nRun++;
    if ({CpuGnt, LdrGnt} !== 2'b01) begin
      nFail++;
      $display("FAIL lock_enter: got %b%b want 01", CpuGnt, LdrGnt);
    end
    nextCycle();
    CpuReq = 1; CpuWe = 0; CpuAddr = 32'h10;
    for (int k = 1; k < 3; k++) begin
      LdrAddr = 32'(k); LdrWData = 32'hA0 + 32'(k);
      @(negedge Clk);
      nRun++;
      if ({CpuGnt, LdrGnt} !== 2'b01) begin
        nFail++;
        $display("FAIL lock_burst_%0d: got %b%b want 01", k, CpuGnt, LdrGnt);
      end
      nextCycle();
    end
    LdrReq = 0;
    @(negedge Clk);
    nRun++;
    if ({CpuGnt, LdrGnt} !== 2'b00) begin
      nFail++;
      $display("FAIL lock_hold_noreq: got %b%b want 00", CpuGnt, LdrGnt);
    end
    nextCycle();
    LdrLock = 0;
    @(negedge Clk);
    nRun++;
    if (CpuGnt !== 1'b0) begin
      nFail++;
      $display("FAIL lock_exit_cycle: got %b want 0", CpuGnt);
    end
    nextCycle();
    @(negedge Clk);
    nRun++;
    if (CpuGnt !== 1'b1) begin
      nFail++;
      $display("FAIL lock_cpu_after: got %b want 1", CpuGnt);
    end
    nextCycle();
    CpuReq = 0;
    @(negedge Clk);
    nRun++;
    if ({CpuRValid, CpuRData, mem[2]} !== {1'b1, 32'hDEADBEEF, 32'hA2}) begin
      nFail++;
      $display("FAIL lock_after_data: got %b %h mem2=%h want 1 deadbeef a2",
               CpuRValid, CpuRData, mem[2]);
    end
    nextCycle();
  endtask

  task automatic test_starve();
    logic [1:0] want;
    CpuReq = 1; CpuWe = 1; CpuAddr = 32'h40; CpuWData = 32'h4;
    LdrReq = 1; LdrWe = 1; LdrAddr = 32'h41; LdrWData = 32'h5;
    for (int i = 0; i < 15; i++) begin
      want = (GUARD && (i % 5 == 4)) ? 2'b01 : 2'b10;
      @(negedge Clk);
      nRun++;
      if ({CpuGnt, LdrGnt} !== want) begin
        nFail++;
        $display("FAIL starve_%0d: got %b%b want %b", i, CpuGnt, LdrGnt, want);
      end
      nextCycle();
    end
    idleInputs();
    nextCycle();
  endtask

  task automatic test_reset_mid_read();
    logic [165:0] allOut;
    CpuReq = 1; CpuWe = 0; CpuAddr = 32'h10;
    @(negedge Clk);
    nRun++;
    if (CpuGnt !== 1'b1) begin
      nFail++;
      $display("FAIL rst_mid_gnt: got %b want 1", CpuGnt);
    end
    nextCycle();
    CpuReq = 0;
    Reset = 1;
    @(negedge Clk);
    allOut = {CpuGnt, LdrGnt, CpuRValid, LdrRValid, MemWrite, MemRead,
              MemAddress, MemWriteData, CpuRData, LdrRData};
    nRun++;
    if (allOut !== '0) begin
      nFail++;
      $display("FAIL rst_mid_outputs: got %h want 0", allOut);
    end
    nextCycle();
    Reset = 0;
    @(negedge Clk);
    nRun++;
    if ({CpuRValid, LdrRValid, CpuRData} !== '0) begin
      nFail++;
      $display("FAIL rst_mid_after: got %b%b %h want 00 0",
               CpuRValid, LdrRValid, CpuRData);
    end
    nextCycle();
    LdrReq = 1; LdrWe = 0; LdrAddr = 32'h10;
    @(negedge Clk);
    nRun++;
    if ({CpuGnt, LdrGnt, MemRead} !== 3'b011) begin
      nFail++;
      $display("FAIL rst_mid_idle_gnt: got %b%b%b want 011",
               CpuGnt, LdrGnt, MemRead);
    end
    nextCycle();
    LdrReq = 0;
    @(negedge Clk);
    nRun++;
    if ({CpuRValid, LdrRValid, LdrRData} !== {2'b01, 32'hDEADBEEF}) begin
      nFail++;
      $display("FAIL rst_mid_ldr_ret: got %b%b %h want 01 deadbeef",
               CpuRValid, LdrRValid, LdrRData);
    end
    nextCycle();
  endtask

  task automatic test_alternating();
    logic [3:0]  wantFlags;
    logic [63:0] wantData;
    for (int i = 0; i < 8; i++) ldrWrite(32'h50 + 32'(i), 32'hC0DE0000 + 32'(i));
    for (int i = 0; i < 9; i++) begin
      idleInputs();
      if (i < 8) begin
        if (i % 2 == 0) begin
          CpuReq = 1; CpuAddr = 32'h50 + 32'(i);
        end else begin
          LdrReq = 1; LdrAddr = 32'h50 + 32'(i);
        end
      end
      wantFlags = 4'b0000;
      wantData = '0;
      if (i < 8) wantFlags[3:2] = (i % 2 == 0) ? 2'b10 : 2'b01;
      if (i > 0) begin
        if ((i - 1) % 2 == 0) begin
          wantFlags[1:0] = 2'b10;
          wantData = {32'hC0DE0000 + 32'(i - 1), 32'h0};
        end else begin
          wantFlags[1:0] = 2'b01;
          wantData = {32'h0, 32'hC0DE0000 + 32'(i - 1)};
        end
      end
      @(negedge Clk);
      nRun++;
      if ({CpuGnt, LdrGnt, CpuRValid, LdrRValid, CpuRData, LdrRData}
          !== {wantFlags, wantData}) begin
        nFail++;
        $display("FAIL alt_%0d: got %b%b%b%b %h %h want %b %h",
                 i, CpuGnt, LdrGnt, CpuRValid, LdrRValid,
                 CpuRData, LdrRData, wantFlags, wantData);
      end
      nextCycle();
    end
    idleInputs();
  endtask

  task automatic test_random();
    logic [31:0] refMem [0:15];
    bit          mLocked, mPend, mPendLdr, force_, eC, eL, eW, eR;
    int          mCnt;
    logic [31:0] mPendData, eAddr, eWD, eCD, eLD;
    idleInputs();
    for (int k = 0; k < 16; k++) begin
      refMem[k] = $urandom;
      ldrWrite(32'(k), refMem[k]);
    end
    mLocked = 0; mPend = 0; mPendLdr = 0; mCnt = 0; mPendData = 0;
    for (int c = 0; c < 400; c++) begin
      if (mLocked) begin
        eC = 0;
        eL = LdrReq;
      end else begin
        force_ = GUARD && LdrReq && (mCnt == HOLD);
        eC = CpuReq && !force_;
        eL = LdrReq && !eC;
      end
      eAddr = eC ? CpuAddr : (eL ? LdrAddr : 32'h0);
      eWD   = eC ? CpuWData : (eL ? LdrWData : 32'h0);
      eW    = eC ? CpuWe : (eL ? LdrWe : 1'b0);
      eR    = (eC && !CpuWe) || (eL && !LdrWe);
      eCD   = (mPend && !mPendLdr) ? mPendData : 32'h0;
      eLD   = (mPend && mPendLdr) ? mPendData : 32'h0;
      @(negedge Clk);
      nRun++;
      if ({CpuGnt, LdrGnt, CpuRValid, LdrRValid, CpuRData, LdrRData,
           MemAddress, MemWriteData, MemWrite, MemRead}
          !== {eC, eL, mPend && !mPendLdr, mPend && mPendLdr, eCD, eLD,
               eAddr, eWD, eW, eR}) begin
        nFail++;
        $display("FAIL rand_%0d: got g=%b%b v=%b%b %h %h a=%h d=%h w=%b r=%b want g=%b%b v=%b%b %h %h a=%h d=%h w=%b r=%b",
                 c, CpuGnt, LdrGnt, CpuRValid, LdrRValid, CpuRData, LdrRData,
                 MemAddress, MemWriteData, MemWrite, MemRead,
                 eC, eL, mPend && !mPendLdr, mPend && mPendLdr, eCD, eLD,
                 eAddr, eWD, eW, eR);
      end
      mPend = eR;
      mPendLdr = eL;
      if (eR) mPendData = refMem[eAddr[3:0]];
      if (eC || eL) begin
        if (eW) refMem[eAddr[3:0]] = eWD;
      end
      mLocked = mLocked ? LdrLock : (eL && LdrLock);
      if (eL || !LdrReq) mCnt = 0;
      else if (eC) mCnt++;
      nextCycle();
      if (!CpuReq || eC) begin
        CpuReq   = ($urandom_range(0, 9) < 6);
        CpuWe    = 1'($urandom_range(0, 1));
        CpuAddr  = 32'($urandom_range(0, 15));
        CpuWData = $urandom;
      end
      if (!LdrReq || eL) begin
        LdrReq   = ($urandom_range(0, 9) < 5);
        LdrWe    = 1'($urandom_range(0, 1));
        LdrAddr  = 32'($urandom_range(0, 15));
        LdrWData = $urandom;
      end
      if ($urandom_range(0, 5) == 0) LdrLock = ~LdrLock;
    end
    idleInputs();
    nextCycle();
    nextCycle();
  endtask

  initial begin
    idleInputs();
    Reset = 1;
    test_reset();
    test_cpu_read();
    test_both_writes();
    test_lock();
    test_starve();
    test_reset_mid_read();
    test_alternating();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end

endmodule
